// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 slave with an 8x8 register file, all SPI inputs oversampled on clk_50M
module spi_slave_regfile #(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] REG_RESET = 8'h00
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI_bit,
  output logic       MISO_bit,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_strobe,
  output logic [2:0] wr_addr,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, flush;
  logic sclk_d, ss_d, armed, w;
  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [4:0] bit_cnt;
  logic [6:0] cmd_sr;
  logic [7:0] tx_sr, rx_sr;
  logic [2:0] addr, cmd_addr;
  logic [7:0] regs [8];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
  assign ss_rise = ss_s & ~ss_d;
  // armed ignores the SS fall produced by reset values draining out of the synchroniser mid-frame
  assign ss_fall = ~ss_s & ss_d & armed;
  assign cmd_addr = {cmd_sr[1:0], mosi_s};
  assign rd_data = regs[rd_addr];
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = ss_fall ? CMD : IDLE;
      CMD:  state_n = ss_rise ? IDLE : (sclk_rise && bit_cnt == 5'd7) ? DATA : CMD;
      DATA: state_n = ss_rise ? IDLE : (sclk_rise && bit_cnt == 5'd15) ? DONE : DATA;
      DONE: state_n = ss_rise ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      sclk_sync <= '0;
      ss_sync <= '1;
      mosi_sync <= '0;
      flush <= '0;
      sclk_d <= 1'b0;
      ss_d <= 1'b1;
      armed <= 1'b0;
      state <= IDLE;
      bit_cnt <= '0;
      cmd_sr <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      addr <= '0;
      w <= 1'b0;
      MISO_bit <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= REG_RESET;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI_bit};
      flush <= {flush[SYNC_STAGES-2:0], 1'b1};
      sclk_d <= sclk_s;
      ss_d <= ss_s;
      armed <= armed | (flush[SYNC_STAGES-1] & ss_s);
      state <= state_n;
      frame_err <= ss_rise && ((state == CMD && bit_cnt != 5'd0) || state == DATA);
      wr_strobe <= state == DATA && sclk_rise && bit_cnt == 5'd15 && w;
      if (state == DATA && sclk_rise && bit_cnt == 5'd15 && w) wr_addr <= addr;
      if (wr_strobe) regs[wr_addr] <= rx_sr;
      if (state == IDLE) bit_cnt <= '0;
      else if (sclk_rise && state != DONE) bit_cnt <= bit_cnt + 5'd1;
      if (state == CMD && sclk_rise) begin
        cmd_sr <= {cmd_sr[5:0], mosi_s};
        if (bit_cnt == 5'd7) begin
          addr <= cmd_addr;
          w <= cmd_sr[6];
          tx_sr <= regs[cmd_addr];
        end
      end
      if (state == DATA && sclk_rise) rx_sr <= {rx_sr[6:0], mosi_s};
      if (state == DATA && sclk_fall) tx_sr <= {tx_sr[6:0], 1'b0};
      MISO_bit <= state_n == IDLE ? 1'b0 : (state == DATA && sclk_fall) ? tx_sr[7] : MISO_bit;
    end
  end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: drives SPI frames from a vector table and scoreboards MISO bits and write commits
`timescale 1ns/1ps
module tb_spi_slave_regfile;
  localparam int HP = 4;
  localparam int GAP = 6;
  localparam int NV = 11;
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    int rises;
    int exp_ws;
    int exp_fe;
  } vec_t;
  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;
  logic clk_50M = 1'b0;
  logic reset = 1'b0;
  logic SCLK = 1'b0;
  logic SS = 1'b1;
  logic MOSI_bit = 1'b0;
  logic [2:0] rd_addr = 3'd0;
  logic MISO_bit, wr_strobe, frame_err;
  logic [2:0] wr_addr;
  logic [7:0] rd_data;
  int errors = 0;
  int checks = 0;
  int ws_cnt = 0;
  int fe_cnt = 0;
  int bidx = 0;
  bit mq[$];
  wr_t wq[$];
  wr_t wcur;
  logic [7:0] mem [8];
  vec_t tbl [NV];

  spi_slave_regfile #(.SYNC_STAGES(2), .REG_RESET(8'h00)) dut (
    .clk_50M(clk_50M), .reset(reset), .SCLK(SCLK), .SS(SS), .MOSI_bit(MOSI_bit),
    .MISO_bit(MISO_bit), .rd_addr(rd_addr), .rd_data(rd_data), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input int rises, input bit push, input int rst_bit);
    logic [15:0] word;
    word = {cmd, data};
    rd_addr = cmd[2:0];
    if (push) for (int b = 8; b < rises && b < 16; b++) mq.push_back(mem[cmd[2:0]][15-b]);
    @(negedge clk_50M);
    SS = 1'b0;
    wait_clk(HP);
    for (int i = 0; i < rises; i++) begin
      MOSI_bit = i < 16 ? word[15-i] : 1'b0;
      wait_clk(HP);
      if (i == rst_bit) begin
        reset = 1'b0;
        wait_clk(1);
        chk("rst_miso", 8'(MISO_bit), 8'h00);
        chk("rst_wr_strobe", 8'(wr_strobe), 8'h00);
        chk("rst_wr_addr", 8'(wr_addr), 8'h00);
        chk("rst_frame_err", 8'(frame_err), 8'h00);
        reset = 1'b1;
      end
      SCLK = 1'b1;
      wait_clk(HP);
      SCLK = 1'b0;
    end
    wait_clk(HP);
    SS = 1'b1;
    MOSI_bit = 1'b0;
    wait_clk(GAP);
    chk("idle_miso", 8'(MISO_bit), 8'h00);
  endtask

  always @(posedge SCLK or negedge SS) begin
    if (!SCLK) bidx = 0;
    else if (!SS) begin
      if (bidx < 8) chk("miso_cmd", 8'(MISO_bit), 8'h00);
      else if (bidx < 16 && mq.size() > 0) chk($sformatf("miso_bit%0d", bidx), 8'(MISO_bit), 8'(mq.pop_front()));
      bidx++;
    end
  end

  always @(negedge clk_50M) if (frame_err === 1'b1) fe_cnt++;

  always @(negedge clk_50M) begin
    if (wr_strobe === 1'b1) begin
      ws_cnt++;
      if (wq.size() == 0) chk("wr_unexpected", 8'(wr_addr), 8'hFF);
      else begin
        wcur = wq.pop_front();
        chk("wr_addr", 8'(wr_addr), 8'(wcur.addr));
        @(negedge clk_50M);
        chk("wr_strobe_1cyc", 8'(wr_strobe), 8'h00);
        chk("rd_collision", rd_data, wcur.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ws0, fe0;
    tbl[0]  = '{8'h03, 8'h00, 16, 0, 0};
    tbl[1]  = '{8'h85, 8'hA7, 16, 1, 0};
    tbl[2]  = '{8'h05, 8'h00, 16, 0, 0};
    tbl[3]  = '{8'h82, 8'h5C, 11, 0, 1};
    tbl[4]  = '{8'h02, 8'hFF, 16, 0, 0};
    tbl[5]  = '{8'h82, 8'h3C, 16, 1, 0};
    tbl[6]  = '{8'h02, 8'h00, 20, 0, 0};
    tbl[7]  = '{8'hF9, 8'h5A, 16, 1, 0};
    tbl[8]  = '{8'h81, 8'h00, 0, 0, 0};
    tbl[9]  = '{8'h86, 8'h00, 5, 0, 1};
    tbl[10] = '{8'h86, 8'h00, 8, 0, 1};
    for (int a = 0; a < 8; a++) mem[a] = 8'h00;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(8);
    chk("reset_miso", 8'(MISO_bit), 8'h00);
    chk("reset_wr_strobe", 8'(wr_strobe), 8'h00);
    chk("reset_wr_addr", 8'(wr_addr), 8'h00);
    chk("reset_frame_err", 8'(frame_err), 8'h00);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1;
      chk($sformatf("reset_reg%0d", a), rd_data, 8'h00);
    end
    for (int k = 0; k < NV; k++) begin
      ws0 = ws_cnt;
      fe0 = fe_cnt;
      if (tbl[k].exp_ws != 0) wq.push_back('{tbl[k].cmd[2:0], tbl[k].data});
      frame(tbl[k].cmd, tbl[k].data, tbl[k].rises, 1'b1, -1);
      chk($sformatf("vec%0d_strobes", k), 8'(ws_cnt - ws0), 8'(tbl[k].exp_ws));
      chk($sformatf("vec%0d_frame_err", k), 8'(fe_cnt - fe0), 8'(tbl[k].exp_fe));
      if (tbl[k].exp_ws != 0) mem[tbl[k].cmd[2:0]] = tbl[k].data;
      rd_addr = tbl[k].cmd[2:0];
      #1;
      chk($sformatf("vec%0d_rd_data", k), rd_data, mem[tbl[k].cmd[2:0]]);
    end
    ws0 = ws_cnt;
    fe0 = fe_cnt;
    frame(8'h81, 8'h99, 16, 1'b0, 12);
    for (int a = 0; a < 8; a++) mem[a] = 8'h00;
    chk("rst_frame_strobes", 8'(ws_cnt - ws0), 8'h00);
    chk("rst_frame_err_pulses", 8'(fe_cnt - fe0), 8'h00);
    rd_addr = 3'd1;
    #1;
    chk("rst_reg1", rd_data, 8'h00);
    ws0 = ws_cnt;
    for (int i = 0; i < 8; i++) begin
      wq.push_back('{3'(i), 8'(8'h10 + i)});
      frame(8'(8'h80 | i), 8'(8'h10 + i), 16, 1'b1, -1);
      mem[i] = 8'(8'h10 + i);
    end
    chk("b2b_strobes", 8'(ws_cnt - ws0), 8'h08);
    for (int i = 0; i < 8; i++) frame(8'(i), 8'h00, 16, 1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("b2b_rd%0d", i), rd_data, 8'(8'h10 + i));
    end
    chk("wr_queue_empty", 8'(wq.size()), 8'h00);
    chk("miso_queue_empty", 8'(mq.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
